// File: rtl/fir_ctrl_pkg.sv
// Shared state type and default geometry for the folded 5-tap FIR sequencer.
package fir_ctrl_pkg;

    localparam int DEF_TAPS = 5;
    localparam int DEF_CW   = 12;
    localparam int DEF_AW   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fir_state_t;

    // Tap index of the last cycle in a frame; the bank swap and out_valid key off it.
    function automatic int frame_last_tap(input int taps);
        return taps - 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow written over the config port,
// copied wholesale into the active bank, active[tap] presented as a registered output.
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = DEF_TAPS,
    parameter int CW   = DEF_CW,
    parameter int AW   = DEF_AW
) (
    input  logic          clk100,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic          copy,
    input  logic [AW-1:0] rd_tap,
    output logic [CW-1:0] coef_out
);

    logic [CW-1:0] shadow_q [TAPS];
    logic [CW-1:0] shadow_d [TAPS];
    logic [CW-1:0] active_q [TAPS];
    logic [CW-1:0] active_d [TAPS];
    logic [CW-1:0] coef_d;

    // A write and a copy in the same cycle: the copy sees the freshly written shadow.
    always_comb begin
        coef_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            shadow_d[i] = (wr_en && wr_addr == AW'(i)) ? wr_data : shadow_q[i];
            active_d[i] = copy ? shadow_d[i] : active_q[i];
        end
        for (int i = 0; i < TAPS; i++) begin
            if (rd_tap == AW'(i)) coef_d = active_d[i];
        end
    end

    always_ff @(posedge clk100) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            coef_out <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            coef_out <= coef_d;
        end
    end

endmodule

// File: rtl/fir_fold_ctrl.sv
// Single-clock sequencer for the folded FIR MAC: tap counter, MAC strobes and
// frame-aligned coefficient commit. Optional frame_cnt output with FIR_CTRL_FRAMECNT_EN.
//   state    | meaning
//   ST_IDLE  | stopped, tap held at 0, commits copy immediately
//   ST_RUN   | counting taps, one frame per TAPS cycles
//   ST_DRAIN | run_en dropped mid-frame, finishing the frame then IDLE
module fir_fold_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = DEF_TAPS,
    parameter int CW   = DEF_CW,
    parameter int AW   = DEF_AW
) (
    input  logic          clk100,
    input  logic          rstn,
    input  logic          run_en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_err,
    output logic          commit_done,
    output logic          sample_en,
    output logic [AW-1:0] tap_sel,
    output logic [CW-1:0] coef_out,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          out_valid,
    output logic          busy
`ifdef FIR_CTRL_FRAMECNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam logic [AW-1:0] TAP_LAST = AW'(frame_last_tap(TAPS));

    fir_state_t    state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic          pending_q, cfg_live_q, cfg_err_q, commit_done_q, out_valid_q;
    logic          frame_end, frame_last, addr_ok, wr_fire, commit_take, copy_now;

    always_comb begin
        state_d = state_q;
        tap_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (run_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                tap_d = frame_end ? '0 : tap_q + AW'(1);
                if (!run_en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                tap_d = frame_end ? '0 : tap_q + AW'(1);
                if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign frame_end   = (tap_q == TAP_LAST);
    assign frame_last  = busy && frame_end;
    assign cfg_ready   = cfg_live_q && !pending_q;
    assign addr_ok     = ({1'b0, cfg_addr} < (AW + 1)'(TAPS));
    assign wr_fire     = cfg_valid && cfg_ready;
    assign commit_take = cfg_commit && !pending_q;
    // Copy only between frames; once commit_done has fired the request is spent.
    assign copy_now    = ((pending_q && !commit_done_q) || commit_take) && (!busy || frame_end);

    always_ff @(posedge clk100) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            tap_q         <= '0;
            pending_q     <= 1'b0;
            cfg_live_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            commit_done_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_q         <= tap_d;
            cfg_live_q    <= 1'b1;
            cfg_err_q     <= wr_fire && !addr_ok;
            commit_done_q <= copy_now;
            out_valid_q   <= frame_last;
            if (commit_done_q) pending_q <= 1'b0;
            else if (commit_take) pending_q <= 1'b1;
        end
    end

    assign tap_sel     = tap_q;
    assign sample_en   = busy && (tap_q == '0);
    assign acc_clr     = busy && (tap_q == '0);
    assign acc_en      = busy && (tap_q != '0);
    assign out_valid   = out_valid_q;
    assign cfg_err     = cfg_err_q;
    assign commit_done = commit_done_q;

    fir_coef_bank #(
        .TAPS (TAPS),
        .CW   (CW),
        .AW   (AW)
    ) u_bank (
        .clk100   (clk100),
        .rstn     (rstn),
        .wr_en    (wr_fire && addr_ok),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .copy     (copy_now),
        .rd_tap   (tap_d),
        .coef_out (coef_out)
    );

`ifdef FIR_CTRL_FRAMECNT_EN
    always_ff @(posedge clk100) begin
        if (!rstn) frame_cnt <= '0;
        else if (frame_last) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
